ahb_req_arbiter: RTL
====================

AHB_REQ_ARBITER -- requirements
Module: ahb_req_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width of requests and HADDR.
REQ-002 SHALL have parameter DATA_W, default 32, meaning width of HWDATA, HRDATA, write data and read data.
REQ-003 SHALL have port HCLK, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port HRESETn, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have ports reqN_valid, input, 1, and reqN_ready, output, 1, for N=0,1: per-requester command handshake.
REQ-006 SHALL have ports reqN_addr (input, ADDR_W), reqN_wdata (input, DATA_W), reqN_size (input, 3) and reqN_write (input, 1): per-requester command fields.
REQ-007 SHALL have ports rsp_valid (output, 1), rsp_id (output, 1), rsp_rdata (output, DATA_W) and rsp_err (output, 1): completion pulse, owning requester, read data and error flag.
REQ-008 SHALL have AHB-Lite manager ports HADDR (output, ADDR_W), HWDATA (output, DATA_W), HSIZE (output, 3), HTRANS (output, 2) and HWRITE (output, 1).
REQ-009 SHALL have AHB-Lite manager ports HREADY (input, 1), HRDATA (input, DATA_W) and HRESP (input, 1).

Function
REQ-010 SHALL share one AHB-Lite manager port between two requesters, issuing single NONSEQ transfers only; HTRANS values are IDLE=2'b00 and NONSEQ=2'b10.
REQ-011 SHALL hold an address-phase slot (A) and a data-phase slot (D), each valid or empty; A and D may both be valid at once (pipelined).
REQ-012 SHALL define adv = !A_valid | HREADY; reqN_ready = adv AND this requester wins arbitration; at most one reqN_ready high per cycle.
REQ-013 SHALL arbitrate round-robin: with one valid requester, grant it; with both valid, grant the one not granted last; after reset, requester 0 counts as last-granted-1, so requester 0 wins the first tie.
REQ-014 SHALL, on an accept edge, load A from the winner's fields and drive them from the next cycle: HADDR=addr, HSIZE=size, HWRITE=write, HTRANS=NONSEQ; the wdata and id are held in A.
REQ-015 SHALL drive HTRANS=IDLE whenever A is empty; HADDR, HSIZE and HWRITE then hold their last values.
REQ-016 SHALL hold A's outputs stable while HREADY=0.
REQ-017 SHALL, on an edge with A valid and HREADY=1, move A into D and drive HWDATA=A.wdata from the next cycle, holding it until D retires.
REQ-018 SHALL retire D on an edge with D valid and HREADY=1, pulsing rsp_valid for exactly the next cycle with rsp_id=D.id, rsp_err=HRESP and rsp_rdata=HRDATA sampled at that edge; rsp_rdata SHALL be 0 for writes.
REQ-019 SHALL allow, on the same edge, retirement of D, the A-to-D move and acceptance of a new request into A; this gives back-to-back transfers with zero wait states at 1 transfer per cycle.
REQ-020 SHALL never cancel a pipelined transfer on an error response; the AHB HRESP two-cycle sequence is tolerated, and the error is reported only on the retiring edge (HRESP=1, HREADY=1).
REQ-021 SHALL pass reqN_size unchanged, with no alignment or size checking; requesters are responsible for legal sizes (at most Word32Bit for DATA_W=32).
REQ-022 SHALL provide no backpressure on the response channel; rsp_valid is a single-cycle pulse per completed transfer, in issue order.

Reset
REQ-023 SHALL, on an edge with HRESETn=0, clear A and D, set HTRANS=IDLE, set HADDR, HWDATA, HSIZE and HWRITE to 0, set rsp_valid, rsp_id, rsp_rdata and rsp_err to 0, and reset the round-robin pointer (REQ-013).
REQ-024 SHALL hold reqN_ready=0 while HRESETn=0.
REQ-025 SHALL drop any in-flight transfer on reset mid-operation with no response pulse; the first accept is possible on the first edge with HRESETn=1.

Verification
REQ-026 SHALL verify single write: req0 addr=0x1000, wdata=0x12, size=0, write=1, HREADY=1 -> next cycle HTRANS=NONSEQ, HADDR=0x1000; the cycle after, HTRANS=IDLE, HWDATA=0x12; the cycle after, rsp_valid=1, rsp_id=0, rsp_err=0.
REQ-027 SHALL verify tie arbitration: both requesters hold valid for 4 accepts -> grant order 0,1,0,1, with HTRANS=NONSEQ on 4 consecutive cycles and 4 rsp pulses in the same order.
REQ-028 SHALL verify wait states: read 0x1008 with HREADY=0 for 3 cycles in the data phase, then HRDATA=0x789abcde with HREADY=1 -> HADDR/HWDATA stable throughout, reqN_ready=0 while A is blocked, then rsp_rdata=0x789abcde.
REQ-029 SHALL verify error: HRESP=1/HREADY=0, then HRESP=1/HREADY=1 on the data phase of req1 -> rsp_err=1, rsp_id=1; the pipelined following transfer completes normally with rsp_err=0.
REQ-030 SHALL verify reset mid-transfer: HRESETn=0 for one edge while A and D are valid -> next cycle HTRANS=IDLE, all outputs 0, no rsp pulse; req0 wins the first tie after release.

Source files
------------

// File: rtl/ahb_req_arbiter.sv
// Two-requester round-robin front end for a single AHB-Lite manager port.
// Issues single NONSEQ transfers with a pipelined address slot (A) and data slot (D).
module ahb_req_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [2:0]        req0_size,
    input  logic              req0_write,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic [2:0]        req1_size,
    input  logic              req1_write,

    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,

    output logic [ADDR_W-1:0] HADDR,
    output logic [DATA_W-1:0] HWDATA,
    output logic [2:0]        HSIZE,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    input  logic              HREADY,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HRESP
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    // Address slot: HADDR/HSIZE/HWRITE double as A's fields.
    logic              a_valid;
    logic              a_id;
    logic [DATA_W-1:0] a_wdata;

    // Data slot: HWDATA doubles as D's write data.
    logic              d_valid;
    logic              d_id;
    logic              d_write;

    logic              last_grant;

    logic              adv;
    logic              winner;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [2:0]        sel_size;
    logic              sel_write;

    // Handshake: a command transfers on a rising edge where reqN_valid and
    // reqN_ready are both high; ready is only raised for the arbitration winner.
    always_comb begin
        adv       = !a_valid || HREADY;
        winner    = (req0_valid && req1_valid) ? !last_grant : req1_valid;
        accept    = HRESETn && adv && (req0_valid || req1_valid);
        sel_addr  = winner ? req1_addr  : req0_addr;
        sel_wdata = winner ? req1_wdata : req0_wdata;
        sel_size  = winner ? req1_size  : req0_size;
        sel_write = winner ? req1_write : req0_write;
    end

    assign req0_ready = accept && !winner;
    assign req1_ready = accept && winner;
    assign HTRANS     = a_valid ? TRANS_NONSEQ : TRANS_IDLE;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            a_valid    <= 1'b0;
            a_id       <= 1'b0;
            a_wdata    <= '0;
            d_valid    <= 1'b0;
            d_id       <= 1'b0;
            d_write    <= 1'b0;
            last_grant <= 1'b1;
            HADDR      <= '0;
            HWDATA     <= '0;
            HSIZE      <= 3'd0;
            HWRITE     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            // Retire D: the response reflects HRDATA/HRESP on this edge.
            rsp_valid <= d_valid && HREADY;
            if (d_valid && HREADY) begin
                rsp_id    <= d_id;
                rsp_err   <= HRESP;
                rsp_rdata <= d_write ? '0 : HRDATA;
            end

            if (a_valid && HREADY) begin
                d_valid <= 1'b1;
                d_id    <= a_id;
                d_write <= HWRITE;
                HWDATA  <= a_wdata;
            end else if (HREADY) begin
                d_valid <= 1'b0;
            end

            if (accept) begin
                a_valid    <= 1'b1;
                a_id       <= winner;
                a_wdata    <= sel_wdata;
                HADDR      <= sel_addr;
                HSIZE      <= sel_size;
                HWRITE     <= sel_write;
                last_grant <= winner;
            end else if (HREADY) begin
                a_valid <= 1'b0;
            end
        end
    end

endmodule
